// File: rtl/pwm_capture_if.sv
// pwm_capture_if: groups the PWM input and the measurement results.
// master = measuring side (pwm_capture), slave = consumer of the readings.
interface pwm_capture_if #(
    parameter int WIDTH = 19
) ();
    logic             pwm_in;
    logic             pwm_level;
    logic [WIDTH-1:0] pulse_width;
    logic [WIDTH-1:0] period;
    logic             sample_valid;
    logic             signal_lost;

    modport master (
        input  pwm_in,
        output pwm_level,
        output pulse_width,
        output period,
        output sample_valid,
        output signal_lost
    );

    modport slave (
        output pwm_in,
        input  pwm_level,
        input  pulse_width,
        input  period,
        input  sample_valid,
        input  signal_lost
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of one PWM input
// in clk cycles, strobes both once per period and flags loss of signal.
// Optional glitch filter: define PWM_CAP_FILTER_EN to enable it.
module pwm_capture #(
    parameter int WIDTH          = 19,
    parameter int TIMEOUT_CYCLES = 480000,
    parameter int FILTER_LEN     = 4
) (
    input  logic          clk,
    input  logic          reset,
    pwm_capture_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W    = WIDTH'(0);

    logic [1:0]       sync_r;
    logic             lvl_r;
    logic             lvl_d_r;
    logic             rise_s;
    logic             fall_s;
    state_t           state_r;
    logic [WIDTH-1:0] high_cnt_r;
    logic [WIDTH-1:0] per_cnt_r;
    logic [WIDTH-1:0] width_r;
    logic [WIDTH-1:0] pulse_width_r;
    logic [WIDTH-1:0] period_r;
    logic             sample_valid_r;
    logic             signal_lost_r;

    // Two-flop synchronizer for the asynchronous input plus the delayed level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= 2'b00;
            lvl_d_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], bus.pwm_in};
            lvl_d_r <= lvl_r;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

    logic [FCW-1:0] filt_cnt_r;
    logic           filt_r;

    // Accept a new level only after FILTER_LEN consecutive agreeing samples; then register once more so both edges see the same delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt_r <= {FCW{1'b0}};
            filt_r     <= 1'b0;
            lvl_r      <= 1'b0;
        end else begin
            lvl_r <= filt_r;
            if (sync_r[1] == filt_r) begin
                filt_cnt_r <= {FCW{1'b0}};
            end else if (filt_cnt_r == FILT_LAST) begin
                filt_r     <= sync_r[1];
                filt_cnt_r <= {FCW{1'b0}};
            end else begin
                filt_cnt_r <= filt_cnt_r + FCW'(1);
            end
        end
    end
`else
    // Unfiltered path: synchronizer output registered once.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_r <= 1'b0;
        end else begin
            lvl_r <= sync_r[1];
        end
    end
`endif

    // Edge detection from the registered level and its one-cycle delayed copy.
    always_comb begin
        rise_s = 1'b0;
        fall_s = 1'b0;
        if (lvl_r && !lvl_d_r) begin
            rise_s = 1'b1;
        end else if (!lvl_r && lvl_d_r) begin
            fall_s = 1'b1;
        end else begin
            rise_s = 1'b0;
            fall_s = 1'b0;
        end
    end

    // Measurement FSM: counts high time and period, emits samples on rises and declares loss on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            high_cnt_r     <= ZERO_W;
            per_cnt_r      <= ZERO_W;
            width_r        <= ZERO_W;
            pulse_width_r  <= ZERO_W;
            period_r       <= ZERO_W;
            sample_valid_r <= 1'b0;
            signal_lost_r  <= 1'b1;
        end else begin
            sample_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Period incomplete on the first rise, so no sample yet.
                    if (rise_s) begin
                        high_cnt_r <= ONE_W;
                        per_cnt_r  <= ONE_W;
                        state_r    <= HIGH;
                    end
                end
                HIGH: begin
                    // A rise cannot occur here: a fall must come first.
                    if (per_cnt_r == TIMEOUT_W) begin
                        state_r       <= IDLE;
                        signal_lost_r <= 1'b1;
                        pulse_width_r <= ZERO_W;
                        period_r      <= ZERO_W;
                    end else if (fall_s) begin
                        width_r   <= high_cnt_r;
                        per_cnt_r <= per_cnt_r + ONE_W;
                        state_r   <= LOW;
                    end else begin
                        high_cnt_r <= high_cnt_r + ONE_W;
                        per_cnt_r  <= per_cnt_r + ONE_W;
                    end
                end
                LOW: begin
                    // The rise takes priority over a timeout in the same cycle.
                    if (rise_s) begin
                        pulse_width_r  <= width_r;
                        period_r       <= per_cnt_r;
                        sample_valid_r <= 1'b1;
                        signal_lost_r  <= 1'b0;
                        high_cnt_r     <= ONE_W;
                        per_cnt_r      <= ONE_W;
                        state_r        <= HIGH;
                    end else if (per_cnt_r == TIMEOUT_W) begin
                        state_r       <= IDLE;
                        signal_lost_r <= 1'b1;
                        pulse_width_r <= ZERO_W;
                        period_r      <= ZERO_W;
                    end else begin
                        per_cnt_r <= per_cnt_r + ONE_W;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.pwm_level    = lvl_r;
    assign bus.pulse_width  = pulse_width_r;
    assign bus.period       = period_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.signal_lost  = signal_lost_r;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed scenarios for pwm_capture with scaled-down timing
// (WIDTH=12, TIMEOUT_CYCLES=3000) so the run stays short.
module tb_pwm_capture;
    localparam int W = 12;
    localparam int T = 3000;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;
    int   sw_q[$];
    int   sp_q[$];
    int   sc_q[$];
    int   lost_cyc;
    logic lost_prev;
    logic sv_prev;
    int   consec;

    pwm_capture_if #(.WIDTH(W)) bus ();

    pwm_capture #(
        .WIDTH(W),
        .TIMEOUT_CYCLES(T),
        .FILTER_LEN(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe / loss monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.sample_valid === 1'b1) begin
            sw_q.push_back(int'(bus.pulse_width));
            sp_q.push_back(int'(bus.period));
            sc_q.push_back(cyc);
            if (sv_prev === 1'b1) consec = consec + 1;
        end
        if (bus.signal_lost === 1'b1 && lost_prev !== 1'b1) lost_cyc = cyc;
        lost_prev = bus.signal_lost;
        sv_prev   = bus.sample_valid;
    end

    task automatic drive(input logic v, input int n);
        bus.pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus.pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.pulse_width !== 12'd0) begin errors++; $display("FAIL reset_pw: got %0d expected 0", bus.pulse_width); end
        checks++; if (bus.period !== 12'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", bus.period); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b expected 0", bus.sample_valid); end
        checks++; if (bus.signal_lost !== 1'b1) begin errors++; $display("FAIL reset_lost: got %b expected 1", bus.signal_lost); end
        checks++; if (bus.pwm_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", bus.pwm_level); end
    endtask

    task automatic test_servo();
        int base;
        apply_reset();
        base = sw_q.size();
        drive(1'b1, 180);
        drive(1'b0, 2221);
        checks++; if (sw_q.size() - base !== 0) begin errors++; $display("FAIL servo_first_rise: got %0d strobes expected 0", sw_q.size() - base); end
        checks++; if (bus.signal_lost !== 1'b1) begin errors++; $display("FAIL servo_lost_before: got %b expected 1", bus.signal_lost); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 180);
            drive(1'b0, 2221);
        end
        checks++; if (sw_q.size() - base !== 3) begin errors++; $display("FAIL servo_count: got %0d expected 3", sw_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            if (base + i < sw_q.size()) begin
                checks++; if (sw_q[base+i] !== 180) begin errors++; $display("FAIL servo_pw%0d: got %0d expected 180", i, sw_q[base+i]); end
                checks++; if (sp_q[base+i] !== 2401) begin errors++; $display("FAIL servo_period%0d: got %0d expected 2401", i, sp_q[base+i]); end
            end
        end
        checks++; if (bus.signal_lost !== 1'b0) begin errors++; $display("FAIL servo_lost_after: got %b expected 0", bus.signal_lost); end
    endtask

    task automatic test_esc();
        int base;
        int exp_w[3];
        exp_w[0] = 60; exp_w[1] = 60; exp_w[2] = 66;
        apply_reset();
        base = sw_q.size();
        drive(1'b1, 60); drive(1'b0, 181);
        drive(1'b1, 60); drive(1'b0, 181);
        drive(1'b1, 66); drive(1'b0, 175);
        drive(1'b1, 5);  drive(1'b0, 10);
        checks++; if (sw_q.size() - base !== 3) begin errors++; $display("FAIL esc_count: got %0d expected 3", sw_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            if (base + i < sw_q.size()) begin
                checks++; if (sw_q[base+i] !== exp_w[i]) begin errors++; $display("FAIL esc_pw%0d: got %0d expected %0d", i, sw_q[base+i], exp_w[i]); end
                checks++; if (sp_q[base+i] !== 241) begin errors++; $display("FAIL esc_period%0d: got %0d expected 241", i, sp_q[base+i]); end
            end
        end
    endtask

    task automatic test_stuck(input logic stuck_level);
        int  base;
        int  n;
        bit  seen;
        apply_reset();
        base = sw_q.size();
        drive(1'b1, 180); drive(1'b0, 2221);
        drive(1'b1, 180); drive(1'b0, 2221);
        if (stuck_level) begin
            bus.pwm_in = 1'b1;
        end else begin
            drive(1'b1, 180);
            bus.pwm_in = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (bus.signal_lost === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stuck%0d_timeout_seen: got %b expected 1", stuck_level, seen); end
        n = sw_q.size() - base;
        checks++; if (n !== 2) begin errors++; $display("FAIL stuck%0d_count: got %0d expected 2", stuck_level, n); end
        if (n > 0) begin
            checks++; if (lost_cyc - sc_q[sc_q.size()-1] !== T) begin errors++; $display("FAIL stuck%0d_delay: got %0d expected %0d", stuck_level, lost_cyc - sc_q[sc_q.size()-1], T); end
        end
        checks++; if (bus.pulse_width !== 12'd0) begin errors++; $display("FAIL stuck%0d_pw: got %0d expected 0", stuck_level, bus.pulse_width); end
        checks++; if (bus.period !== 12'd0) begin errors++; $display("FAIL stuck%0d_period: got %0d expected 0", stuck_level, bus.period); end
        base = sw_q.size();
        drive(1'b0, 50);
        drive(1'b1, 180); drive(1'b0, 2221);
        checks++; if (sw_q.size() - base !== 0) begin errors++; $display("FAIL stuck%0d_restart_none: got %0d expected 0", stuck_level, sw_q.size() - base); end
        drive(1'b1, 180); drive(1'b0, 20);
        checks++; if (sw_q.size() - base !== 1) begin errors++; $display("FAIL stuck%0d_restart_one: got %0d expected 1", stuck_level, sw_q.size() - base); end
        if (sw_q.size() - base == 1) begin
            checks++; if (sw_q[base] !== 180 || sp_q[base] !== 2401) begin errors++; $display("FAIL stuck%0d_restart_vals: got %0d/%0d expected 180/2401", stuck_level, sw_q[base], sp_q[base]); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        apply_reset();
        drive(1'b1, 180); drive(1'b0, 2221);
        drive(1'b1, 100);
        checks++; if (bus.pulse_width !== 12'd180) begin errors++; $display("FAIL mid_pre_pw: got %0d expected 180", bus.pulse_width); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.pulse_width !== 12'd0) begin errors++; $display("FAIL mid_pw: got %0d expected 0", bus.pulse_width); end
        checks++; if (bus.period !== 12'd0) begin errors++; $display("FAIL mid_period: got %0d expected 0", bus.period); end
        checks++; if (bus.signal_lost !== 1'b1) begin errors++; $display("FAIL mid_lost: got %b expected 1", bus.signal_lost); end
        checks++; if (bus.pwm_level !== 1'b0) begin errors++; $display("FAIL mid_level: got %b expected 0", bus.pwm_level); end
        base = sw_q.size();
        drive(1'b1, 80);  drive(1'b0, 2221);
        drive(1'b1, 180); drive(1'b0, 2221);
        drive(1'b1, 5);   drive(1'b0, 10);
        checks++; if (sw_q.size() - base !== 2) begin errors++; $display("FAIL mid_count: got %0d expected 2", sw_q.size() - base); end
        if (sw_q.size() > base) begin
            checks++; if (sw_q[sw_q.size()-1] !== 180 || sp_q[sp_q.size()-1] !== 2401) begin errors++; $display("FAIL mid_vals: got %0d/%0d expected 180/2401", sw_q[sw_q.size()-1], sp_q[sp_q.size()-1]); end
        end
    endtask

    task automatic test_glitch();
        int base;
        apply_reset();
        base = sw_q.size();
        drive(1'b1, 180); drive(1'b0, 1000);
        drive(1'b1, 3);   drive(1'b0, 1218);
        drive(1'b1, 5);   drive(1'b0, 10);
`ifdef PWM_CAP_FILTER_EN
        checks++; if (sw_q.size() - base !== 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", sw_q.size() - base); end
        if (sw_q.size() > base) begin
            checks++; if (sw_q[base] !== 180 || sp_q[base] !== 2401) begin errors++; $display("FAIL glitch_vals: got %0d/%0d expected 180/2401", sw_q[base], sp_q[base]); end
        end
`else
        checks++; if (sw_q.size() - base !== 2) begin errors++; $display("FAIL glitch_count: got %0d expected 2", sw_q.size() - base); end
        if (sw_q.size() - base == 2) begin
            checks++; if (sw_q[base] !== 180 || sp_q[base] !== 1180) begin errors++; $display("FAIL glitch_first: got %0d/%0d expected 180/1180", sw_q[base], sp_q[base]); end
            checks++; if (sw_q[base+1] !== 3 || sp_q[base+1] !== 1221) begin errors++; $display("FAIL glitch_second: got %0d/%0d expected 3/1221", sw_q[base+1], sp_q[base+1]); end
        end
`endif
    endtask

    task automatic test_boundary();
        int base;
        apply_reset();
        base = sw_q.size();
        drive(1'b1, 180); drive(1'b0, T - 180);
        drive(1'b1, 180); drive(1'b0, 10);
        checks++; if (sw_q.size() - base !== 1) begin errors++; $display("FAIL bound_count: got %0d expected 1", sw_q.size() - base); end
        if (sw_q.size() > base) begin
            checks++; if (sp_q[base] !== T) begin errors++; $display("FAIL bound_period: got %0d expected %0d", sp_q[base], T); end
            checks++; if (sw_q[base] !== 180) begin errors++; $display("FAIL bound_pw: got %0d expected 180", sw_q[base]); end
        end
        checks++; if (bus.signal_lost !== 1'b0) begin errors++; $display("FAIL bound_lost: got %b expected 0", bus.signal_lost); end
        // One cycle longer: timeout fires first, the late rise restarts from idle.
        base = sw_q.size();
        drive(1'b0, T - 190 + 1);
        drive(1'b1, 5); drive(1'b0, 10);
        checks++; if (sw_q.size() - base !== 0) begin errors++; $display("FAIL bound_over_count: got %0d expected 0", sw_q.size() - base); end
        checks++; if (bus.signal_lost !== 1'b1) begin errors++; $display("FAIL bound_over_lost: got %b expected 1", bus.signal_lost); end
    endtask

    task automatic test_back_to_back();
        checks++; if (consec !== 0) begin errors++; $display("FAIL back_to_back: got %0d consecutive strobes expected 0", consec); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        consec     = 0;
        lost_cyc   = 0;
        lost_prev  = 1'b0;
        sv_prev    = 1'b0;
        reset      = 1'b1;
        bus.pwm_in = 1'b0;
        test_reset();
        test_servo();
        test_esc();
        test_stuck(1'b0);
        test_stuck(1'b1);
        test_reset_mid();
        test_glitch();
        test_boundary();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
